vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised raster timing generator; successor to the two-counter 640x480 scan pair.
- Generates horizontal/vertical sync, data-enable, pixel coordinates and frame/line start strobes for any mode defined by active/porch/sync parameters, with selectable sync polarity.
- Sits in the pixel-clock domain downstream of the clock wizard; drives the video output stage and pixel source.

Parameters:
- WIDTH, 10, bit width of h/v counters and x/y outputs; must hold max(H_TOTAL, V_TOTAL)-1
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync asserted level (0 = active-low)
- VS_POL, 0, vsync asserted level (0 = active-low)

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- cen  in  1  pixel enable; timing advances only when high
- hsync  out  1  horizontal sync, level per HS_POL
- vsync  out  1  vertical sync, level per VS_POL
- de  out  1  high during active pixels (h < H_ACTIVE and v < V_ACTIVE)
- x  out  WIDTH  current horizontal position, 0..H_TOTAL-1
- y  out  WIDTH  current vertical position, 0..V_TOTAL-1
- line_start  out  1  one-cen pulse when x == 0
- frame_start  out  1  one-cen pulse when x == 0 and y == 0

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Internal counters h_cnt/v_cnt hold the position of the next pixel to present.
- On each clk edge with cen=1:
  - all outputs register the decode of (h_cnt, v_cnt);
  - h_cnt increments; at H_TOTAL-1 it wraps to 0 and v_cnt increments;
  - v_cnt wraps to 0 after V_TOTAL-1 when h_cnt also wraps.
- cen=0: counters and all outputs hold; strobes stay at their last value. The bench drives cen as a qualifier, so a strobe is defined as one cen-qualified sample.
- Latency: a pixel appears on the outputs one cen-qualified edge after it is loaded into the counters.
- Per-axis phase state (ACTIVE -> FP -> SYNC -> BP -> ACTIVE):
  - decoded from the count against cumulative boundaries, not a separately stored FSM;
  - each transition occurs at an exact count boundary.
- hsync asserted iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC.
- vsync asserted iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC; vsync edges therefore coincide with x == 0.
- Reset:
  - counters go to 0; x=0, y=0, de=0, line_start=0, frame_start=0;
  - hsync = !HS_POL, vsync = !VS_POL (deasserted).
  - First cen after reset release presents (0,0) with de=1, line_start=1, frame_start=1.
- rst asserted mid-frame: takes effect on the next edge regardless of cen; no partial line is completed.
- rst and cen both high: rst wins.
- Zero-width porch parameters are legal (phase skipped); H_SYNC and V_SYNC must be at least 1.

Decomposition:
- Package vga_timing_pkg:
  - mode constant sets: 640x480@60 (above defaults) and 800x600@60 (800/40/128/88, 600/1/4/23);
  - polarity localparams;
  - phase enum {PH_ACTIVE, PH_FP, PH_SYNC, PH_BP}.
- Sub-module timing_axis, instantiated twice (horizontal, vertical):
  - parameters ACTIVE/FP/SYNC/BP/POL/WIDTH;
  - inputs clk, rst, cen (advance);
  - outputs count, wrap (terminal count), active, sync.
  - Vertical instance advance = cen & horizontal wrap.

Test Plan:
- Reset, then 420000 cen cycles with defaults -> exactly one frame_start, at cycle 1 with (x,y)=(0,0) and de=1; 525 line_start pulses; 307200 de-high cycles.
- Line 0 sweep -> de high for x=0..639; hsync low for x=656..751 (96 cycles); hsync high at x=752..799; x wraps 799->0 with y 0->1.
- Frame scan -> vsync low only on y=490 and y=491 (1600 cycles), first low sample at x=0,y=490; de low for all y>=480; y wraps 524->0 with frame_start.
- cen toggled 1-0-1 with 3-cycle gaps across the x=799 boundary -> outputs hold during gaps; next cen shows x=0, y+1, line_start=1; no skipped or duplicated position.
- rst pulsed at (x=300,y=200) -> next edge x=0, y=0, de=0, sync lines deasserted; first cen afterwards gives frame_start=1.
- Small mode (H 4/1/2/1, V 3/1/1/1, HS_POL=VS_POL=1) -> 8-pixel lines, 6-line frames; hsync high at x=5,6; vsync high for y=4; frame period 48 cen cycles.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared constants, phase encoding and phase decode for the raster timing generator.
// Holds the standard mode parameter sets and the sync polarity names.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FP,
        PH_SYNC,
        PH_BP
    } phase_t;

    localparam bit POL_NEG = 1'b0;
    localparam bit POL_POS = 1'b1;

    // 640x480@60
    localparam int M640_H_ACTIVE = 640;
    localparam int M640_H_FP     = 16;
    localparam int M640_H_SYNC   = 96;
    localparam int M640_H_BP     = 48;
    localparam int M640_V_ACTIVE = 480;
    localparam int M640_V_FP     = 10;
    localparam int M640_V_SYNC   = 2;
    localparam int M640_V_BP     = 33;

    // 800x600@60
    localparam int M800_H_ACTIVE = 800;
    localparam int M800_H_FP     = 40;
    localparam int M800_H_SYNC   = 128;
    localparam int M800_H_BP     = 88;
    localparam int M800_V_ACTIVE = 600;
    localparam int M800_V_FP     = 1;
    localparam int M800_V_SYNC   = 4;
    localparam int M800_V_BP     = 23;

    // Phase from cumulative boundaries; a zero-width porch
    // collapses its range so that phase is never returned.
    function automatic phase_t axis_phase(
        input int cnt,
        input int act,
        input int fp,
        input int sy
    );
        phase_t ph;
        if (cnt < act) begin
            ph = PH_ACTIVE;
        end else if (cnt < act + fp) begin
            ph = PH_FP;
        end else if (cnt < act + fp + sy) begin
            ph = PH_SYNC;
        end else begin
            ph = PH_BP;
        end
        return ph;
    endfunction

endpackage

// File: rtl/timing_axis.sv
// One raster axis: wrapping position counter plus phase decode.
// Ports: clk, rst (sync, high), cen (advance); count, wrap (terminal), active, sync (line level).
module timing_axis
    import vga_timing_pkg::*;
#(
    parameter int WIDTH  = 10,
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter bit POL    = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    output logic [WIDTH-1:0] count,
    output logic             wrap,
    output logic             active,
    output logic             sync
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [WIDTH-1:0] L_LAST = WIDTH'(TOTAL - 1);

    logic [WIDTH-1:0] r_cnt;
    phase_t           w_phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (cen) begin
            if (r_cnt == L_LAST) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + WIDTH'(1);
            end
        end
    end

    assign w_phase = axis_phase(32'(r_cnt), ACTIVE, FP, SYNC);

    assign count  = r_cnt;
    assign wrap   = (r_cnt == L_LAST);
    assign active = (w_phase == PH_ACTIVE);
    // Drive the line level directly so the top only registers it.
    assign sync   = (w_phase == PH_SYNC) ? POL : ~POL;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: syncs, data enable, position, line/frame strobes.
// Ports: clk, rst (sync, high), cen (pixel enable); hsync, vsync, de, x, y, line_start, frame_start.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int WIDTH    = 10,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = POL_NEG,
    parameter bit VS_POL   = POL_NEG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cen,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic             line_start,
    output logic             frame_start
);

    logic [WIDTH-1:0] w_h_cnt;
    logic [WIDTH-1:0] w_v_cnt;
    logic             w_h_wrap;
    logic             w_v_wrap;
    logic             w_h_act;
    logic             w_v_act;
    logic             w_h_sync;
    logic             w_v_sync;
    logic             w_v_adv;

    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic             r_hs;
    logic             r_vs;
    logic             r_de;
    logic             r_ls;
    logic             r_fs;
    logic             r_at_top;

    // Vertical steps once per completed line.
    assign w_v_adv = cen & w_h_wrap;

    timing_axis #(
        .WIDTH  (WIDTH),
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .POL    (HS_POL)
    ) u_h_axis (
        .clk    (clk),
        .rst    (rst),
        .cen    (cen),
        .count  (w_h_cnt),
        .wrap   (w_h_wrap),
        .active (w_h_act),
        .sync   (w_h_sync)
    );

    timing_axis #(
        .WIDTH  (WIDTH),
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .POL    (VS_POL)
    ) u_v_axis (
        .clk    (clk),
        .rst    (rst),
        .cen    (w_v_adv),
        .count  (w_v_cnt),
        .wrap   (w_v_wrap),
        .active (w_v_act),
        .sync   (w_v_sync)
    );

    // Outputs present the counter values one enabled edge late.
    // r_at_top is set while the vertical counter is on line 0, taken
    // from the vertical terminal count at each line wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x      <= '0;
            r_y      <= '0;
            r_hs     <= ~HS_POL;
            r_vs     <= ~VS_POL;
            r_de     <= 1'b0;
            r_ls     <= 1'b0;
            r_fs     <= 1'b0;
            r_at_top <= 1'b1;
        end else if (cen) begin
            r_x  <= w_h_cnt;
            r_y  <= w_v_cnt;
            r_hs <= w_h_sync;
            r_vs <= w_v_sync;
            r_de <= w_h_act & w_v_act;
            r_ls <= (w_h_cnt == '0);
            r_fs <= (w_h_cnt == '0) & r_at_top;
            if (w_h_wrap) begin
                r_at_top <= w_v_wrap;
            end
        end
    end

    assign x           = r_x;
    assign y           = r_y;
    assign hsync       = r_hs;
    assign vsync       = r_vs;
    assign de          = r_de;
    assign line_start  = r_ls;
    assign frame_start = r_fs;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed self-checking bench for vga_timing_gen: default, mid-size and tiny modes
// driven from one clock, reset and pixel enable.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cen = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Default 640x480 instance
    logic       d_hs, d_vs, d_de, d_ls, d_fs;
    logic [9:0] d_x, d_y;

    // Mid mode: H 40/4/8/4 (56), V 30/3/2/5 (40), active-low
    logic       m_hs, m_vs, m_de, m_ls, m_fs;
    logic [9:0] m_x, m_y;

    // Tiny mode: H 4/1/2/1 (8), V 3/1/1/1 (6), active-high
    logic       s_hs, s_vs, s_de, s_ls, s_fs;
    logic [9:0] s_x, s_y;

    vga_timing_gen u_dut (
        .clk         (clk),
        .rst         (rst),
        .cen         (cen),
        .hsync       (d_hs),
        .vsync       (d_vs),
        .de          (d_de),
        .x           (d_x),
        .y           (d_y),
        .line_start  (d_ls),
        .frame_start (d_fs)
    );

    vga_timing_gen #(
        .WIDTH(10), .H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(30), .V_FP(3), .V_SYNC(2), .V_BP(5),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) u_mid (
        .clk         (clk),
        .rst         (rst),
        .cen         (cen),
        .hsync       (m_hs),
        .vsync       (m_vs),
        .de          (m_de),
        .x           (m_x),
        .y           (m_y),
        .line_start  (m_ls),
        .frame_start (m_fs)
    );

    vga_timing_gen #(
        .WIDTH(10), .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) u_small (
        .clk         (clk),
        .rst         (rst),
        .cen         (cen),
        .hsync       (s_hs),
        .vsync       (s_vs),
        .de          (s_de),
        .x           (s_x),
        .y           (s_y),
        .line_start  (s_ls),
        .frame_start (s_fs)
    );

    // One clock with the given enable; outputs are sampled 1 ns after the edge.
    task automatic tick(input logic c);
        cen = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1'b0);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        // cen high during reset: reset must win
        repeat (3) tick(1'b1);
        checks++;
        if ({d_x, d_y} !== 20'd0) begin
            failures++;
            $display("FAIL reset_xy got=%0d,%0d exp=0,0", d_x, d_y);
        end
        checks++;
        if ({d_de, d_ls, d_fs} !== 3'b000) begin
            failures++;
            $display("FAIL reset_strobes got=%b exp=000", {d_de, d_ls, d_fs});
        end
        checks++;
        if ({d_hs, d_vs} !== 2'b11) begin
            failures++;
            $display("FAIL reset_sync_neg got=%b exp=11", {d_hs, d_vs});
        end
        checks++;
        if ({s_hs, s_vs} !== 2'b00) begin
            failures++;
            $display("FAIL reset_sync_pos got=%b exp=00", {s_hs, s_vs});
        end
        rst = 1'b0;
        tick(1'b0);
        checks++;
        if ({d_de, d_ls, d_fs} !== 3'b000) begin
            failures++;
            $display("FAIL release_nocen got=%b exp=000", {d_de, d_ls, d_fs});
        end
        tick(1'b1);
        checks++;
        if ({d_x, d_y} !== 20'd0 || {d_de, d_ls, d_fs} !== 3'b111) begin
            failures++;
            $display("FAIL first_pixel got x=%0d y=%0d de/ls/fs=%b exp x=0 y=0 111",
                     d_x, d_y, {d_de, d_ls, d_fs});
        end
    endtask

    task automatic test_line_sweep();
        int bad;
        logic e_de, e_hs;
        do_reset();
        bad = 0;
        for (int i = 0; i < 800; i++) begin
            tick(1'b1);
            e_de = (i < 640);
            e_hs = !(i >= 656 && i < 752);
            checks++;
            if (d_x !== 10'(i) || d_y !== 10'd0 || d_de !== e_de ||
                d_hs !== e_hs || d_ls !== (i == 0) || d_vs !== 1'b1) begin
                failures++;
                bad++;
                if (bad < 5)
                    $display("FAIL line0 i=%0d got x=%0d y=%0d de=%b hs=%b ls=%b exp de=%b hs=%b",
                             i, d_x, d_y, d_de, d_hs, d_ls, e_de, e_hs);
            end
        end
        tick(1'b1);
        checks++;
        if (d_x !== 10'd0 || d_y !== 10'd1 || d_ls !== 1'b1 || d_fs !== 1'b0) begin
            failures++;
            $display("FAIL line_wrap got x=%0d y=%0d ls=%b fs=%b exp x=0 y=1 ls=1 fs=0",
                     d_x, d_y, d_ls, d_fs);
        end
    endtask

    task automatic test_cen_gaps();
        do_reset();
        repeat (799) tick(1'b1);
        checks++;
        if (d_x !== 10'd798 || d_y !== 10'd0) begin
            failures++;
            $display("FAIL gap_pre got x=%0d y=%0d exp 798,0", d_x, d_y);
        end
        tick(1'b1);
        for (int k = 0; k < 3; k++) begin
            tick(1'b0);
            checks++;
            if (d_x !== 10'd799 || d_y !== 10'd0 || d_ls !== 1'b0 ||
                d_hs !== 1'b1 || d_de !== 1'b0) begin
                failures++;
                $display("FAIL gap_hold799 k=%0d got x=%0d y=%0d ls=%b hs=%b de=%b",
                         k, d_x, d_y, d_ls, d_hs, d_de);
            end
        end
        tick(1'b1);
        checks++;
        if (d_x !== 10'd0 || d_y !== 10'd1 || d_ls !== 1'b1 || d_de !== 1'b1) begin
            failures++;
            $display("FAIL gap_wrap got x=%0d y=%0d ls=%b de=%b exp 0,1 ls=1 de=1",
                     d_x, d_y, d_ls, d_de);
        end
        for (int k = 0; k < 3; k++) begin
            tick(1'b0);
            checks++;
            if (d_x !== 10'd0 || d_y !== 10'd1 || d_ls !== 1'b1) begin
                failures++;
                $display("FAIL gap_hold0 k=%0d got x=%0d y=%0d ls=%b exp 0,1 ls=1",
                         k, d_x, d_y, d_ls);
            end
        end
        tick(1'b1);
        checks++;
        if (d_x !== 10'd1 || d_y !== 10'd1 || d_ls !== 1'b0) begin
            failures++;
            $display("FAIL gap_next got x=%0d y=%0d ls=%b exp 1,1 ls=0",
                     d_x, d_y, d_ls);
        end
    endtask

    task automatic test_frame_mid();
        int fs_n, ls_n, de_n, vs_n, de_bad, vs_bad, pos_bad;
        int vs_fx, vs_fy;
        logic fs_first;
        fs_n = 0; ls_n = 0; de_n = 0; vs_n = 0;
        de_bad = 0; vs_bad = 0; pos_bad = 0;
        vs_fx = -1; vs_fy = -1;
        fs_first = 1'b0;
        do_reset();
        for (int i = 0; i < 2240; i++) begin
            tick(1'b1);
            if (m_x !== 10'(i % 56) || m_y !== 10'(i / 56)) pos_bad++;
            if (m_fs) fs_n++;
            if (m_ls) ls_n++;
            if (m_de) de_n++;
            if (i == 0) fs_first = m_fs & m_de;
            if (m_de && (i / 56) >= 30) de_bad++;
            if (!m_vs) begin
                if (vs_fx < 0) begin
                    vs_fx = int'(m_x);
                    vs_fy = int'(m_y);
                end
                vs_n++;
                if ((i / 56) != 33 && (i / 56) != 34) vs_bad++;
            end
        end
        checks++;
        if (pos_bad != 0) begin
            failures++;
            $display("FAIL mid_pos got=%0d bad positions exp=0", pos_bad);
        end
        checks++;
        if (fs_n != 1 || fs_first !== 1'b1) begin
            failures++;
            $display("FAIL mid_fs got count=%0d first=%b exp 1,1", fs_n, fs_first);
        end
        checks++;
        if (ls_n != 40) begin
            failures++;
            $display("FAIL mid_ls got=%0d exp=40", ls_n);
        end
        checks++;
        if (de_n != 1200 || de_bad != 0) begin
            failures++;
            $display("FAIL mid_de got=%0d bad=%0d exp=1200 bad=0", de_n, de_bad);
        end
        checks++;
        if (vs_n != 112 || vs_bad != 0) begin
            failures++;
            $display("FAIL mid_vs got=%0d bad=%0d exp=112 bad=0", vs_n, vs_bad);
        end
        checks++;
        if (vs_fx != 0 || vs_fy != 33) begin
            failures++;
            $display("FAIL mid_vs_first got=%0d,%0d exp=0,33", vs_fx, vs_fy);
        end
        tick(1'b1);
        checks++;
        if (m_x !== 10'd0 || m_y !== 10'd0 || m_fs !== 1'b1 || m_ls !== 1'b1) begin
            failures++;
            $display("FAIL mid_wrap got x=%0d y=%0d fs=%b ls=%b exp 0,0 1 1",
                     m_x, m_y, m_fs, m_ls);
        end
    endtask

    task automatic test_rst_mid();
        do_reset();
        repeat (1141) tick(1'b1);
        checks++;
        if (m_x !== 10'd20 || m_y !== 10'd20 || m_de !== 1'b1 ||
            d_x !== 10'd340 || d_y !== 10'd1) begin
            failures++;
            $display("FAIL rst_pre got m=%0d,%0d de=%b d=%0d,%0d exp m=20,20 de=1 d=340,1",
                     m_x, m_y, m_de, d_x, d_y);
        end
        rst = 1'b1;
        tick(1'b0);
        rst = 1'b0;
        checks++;
        if (m_x !== 10'd0 || m_y !== 10'd0 || {m_de, m_ls, m_fs} !== 3'b000 ||
            {m_hs, m_vs} !== 2'b11) begin
            failures++;
            $display("FAIL rst_mid got x=%0d y=%0d de/ls/fs=%b hs/vs=%b exp 0,0 000 11",
                     m_x, m_y, {m_de, m_ls, m_fs}, {m_hs, m_vs});
        end
        checks++;
        if (d_x !== 10'd0 || d_y !== 10'd0 || d_de !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_dflt got x=%0d y=%0d de=%b exp 0,0 0", d_x, d_y, d_de);
        end
        tick(1'b1);
        checks++;
        if (m_fs !== 1'b1 || m_x !== 10'd0 || m_y !== 10'd0 || d_fs !== 1'b1) begin
            failures++;
            $display("FAIL rst_restart got m_fs=%b x=%0d y=%0d d_fs=%b exp 1,0,0,1",
                     m_fs, m_x, m_y, d_fs);
        end
    endtask

    task automatic test_small();
        int bad;
        int ex, ey;
        logic e_hs, e_vs, e_de;
        do_reset();
        bad = 0;
        for (int i = 0; i < 48; i++) begin
            tick(1'b1);
            ex = i % 8;
            ey = i / 8;
            e_hs = (ex == 5 || ex == 6);
            e_vs = (ey == 4);
            e_de = (ex < 4 && ey < 3);
            checks++;
            if (s_x !== 10'(ex) || s_y !== 10'(ey) || s_hs !== e_hs ||
                s_vs !== e_vs || s_de !== e_de || s_ls !== (ex == 0) ||
                s_fs !== (i == 0)) begin
                failures++;
                bad++;
                if (bad < 5)
                    $display("FAIL small i=%0d got x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b",
                             i, s_x, s_y, s_hs, s_vs, s_de, s_ls, s_fs);
            end
        end
        tick(1'b1);
        checks++;
        if (s_x !== 10'd0 || s_y !== 10'd0 || s_fs !== 1'b1) begin
            failures++;
            $display("FAIL small_period got x=%0d y=%0d fs=%b exp 0,0,1", s_x, s_y, s_fs);
        end
    endtask

    initial begin
        test_reset();
        test_line_sweep();
        test_cen_gaps();
        test_frame_mid();
        test_rst_mid();
        test_small();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
